// File: rtl/spi_ctrl_regfile_pkg.sv
// Shared register map and transfer decode for the SPI control register bank.
package spi_regs_pkg;

  localparam int ADDR_W = 5;
  localparam int RD_BIT = 5;
  localparam int N_CTRL = 8;

  localparam logic [ADDR_W-1:0] ADDR_CTRL0  = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL1  = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_CTRL2  = 5'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL3  = 5'd4;
  localparam logic [ADDR_W-1:0] ADDR_CTRL4  = 5'd5;
  localparam logic [ADDR_W-1:0] ADDR_CTRL5  = 5'd6;
  localparam logic [ADDR_W-1:0] ADDR_CTRL6  = 5'd7;
  localparam logic [ADDR_W-1:0] ADDR_CTRL7  = 5'd8;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'd9;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CTRL,
    OP_CLEAR,
    OP_BAD
  } op_e;

  // Read transfers never touch write-side state, whatever address they carry.
  function automatic op_e decode_op(input logic rd, input logic [ADDR_W-1:0] addr);
    if (rd)
      return OP_NONE;
    if (addr >= ADDR_CTRL0 && addr <= ADDR_CTRL7)
      return OP_CTRL;
    if (addr == ADDR_STATUS)
      return OP_CLEAR;
    return OP_BAD;
  endfunction

endpackage

// File: rtl/spi_ctrl_regfile_if.sv
// Transfer bus from the Ozy GPIO SPI slave into the control register bank.
interface spi_ctrl_regfile_if #(
  parameter int WIDTH = 8
);
  logic [6:0]       saddr;
  logic [WIDTH-1:0] sdata;
  logic             sstrobe;

  modport master (output saddr, sdata, sstrobe);
  modport slave  (input  saddr, sdata, sstrobe);
endinterface

// File: rtl/spi_sticky_status.sv
// Sticky event register: level events set bits, a write-1-to-clear mask
// clears them, and a set in the same cycle as a clear keeps the bit at 1.
module spi_sticky_status #(
  parameter int WIDTH = 8
) (
  input  logic             FX2_CLK,
  input  logic             FX2_RST_n,
  input  logic [WIDTH-1:0] event_in,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] status
);

  logic [WIDTH-1:0] status_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and the simulation order of processes cannot matter.
  always_ff @(posedge FX2_CLK or negedge FX2_RST_n) begin
    if (!FX2_RST_n)
      status_q <= '0;
    else
      status_q <= (status_q & ~clr_mask) | event_in;
  end

  assign status = status_q;

endmodule

// File: rtl/spi_ctrl_regfile.sv
// Write-side register bank behind the SPI slave: capture stage, commit decode,
// eight control registers, sticky status, write counter and error flag.
module spi_ctrl_regfile
  import spi_regs_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] CTRL_RST = {WIDTH{1'b0}}
) (
  input  logic                FX2_CLK,
  input  logic                FX2_RST_n,
  spi_ctrl_regfile_if.slave   bus,
  input  logic [WIDTH-1:0]    event_in,
  output logic [WIDTH-1:0]    ctrl0,
  output logic [WIDTH-1:0]    ctrl1,
  output logic [WIDTH-1:0]    ctrl2,
  output logic [WIDTH-1:0]    ctrl3,
  output logic [WIDTH-1:0]    ctrl4,
  output logic [WIDTH-1:0]    ctrl5,
  output logic [WIDTH-1:0]    ctrl6,
  output logic [WIDTH-1:0]    ctrl7,
  output logic [N_CTRL-1:0]   wr_pulse,
  output logic [WIDTH-1:0]    status,
  output logic [WIDTH-1:0]    wr_count,
  output logic                err
);

  // Bit 6 of the slave address has no meaning on the write side.
  logic unused_saddr_msb;
  assign unused_saddr_msb = bus.saddr[6];

  logic              cap_vld;
  logic              cap_rd;
  logic [ADDR_W-1:0] cap_addr;
  logic [WIDTH-1:0]  cap_data;

  // Stage 1: sample the slave's address/data only in the strobe cycle.
  always_ff @(posedge FX2_CLK or negedge FX2_RST_n) begin
    if (!FX2_RST_n) begin
      cap_vld  <= 1'b0;
      cap_rd   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      cap_vld <= bus.sstrobe;
      if (bus.sstrobe) begin
        cap_rd   <= bus.saddr[RD_BIT];
        cap_addr <= bus.saddr[ADDR_W-1:0];
        cap_data <= bus.sdata;
      end
    end
  end

  op_e              op;
  logic [2:0]       ctrl_idx;
  logic [WIDTH-1:0] clr_mask;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    op       = OP_NONE;
    ctrl_idx = 3'(cap_addr - ADDR_CTRL0);
    clr_mask = '0;
    if (cap_vld)
      op = decode_op(cap_rd, cap_addr);
    if (op == OP_CLEAR)
      clr_mask = cap_data;
  end

  logic [WIDTH-1:0]  ctrl_q [N_CTRL];
  logic [N_CTRL-1:0] wr_pulse_q;
  logic [WIDTH-1:0]  wr_count_q;
  logic              err_q;

  // Stage 2: commit the captured transfer one edge after capture.
  // NOTE: the control array is only eight registers wide and must come out of
  // reset at CTRL_RST, so it is reset like ordinary flops, not left as memory.
  always_ff @(posedge FX2_CLK or negedge FX2_RST_n) begin
    if (!FX2_RST_n) begin
      for (int i = 0; i < N_CTRL; i++)
        ctrl_q[i] <= CTRL_RST;
      wr_pulse_q <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_pulse_q <= '0;
      unique case (op)
        OP_CTRL: begin
          ctrl_q[ctrl_idx] <= cap_data;
          wr_pulse_q       <= N_CTRL'(1) << ctrl_idx;
          wr_count_q       <= wr_count_q + WIDTH'(1);
        end
        OP_CLEAR: wr_count_q <= wr_count_q + WIDTH'(1);
        OP_BAD:   err_q      <= 1'b1;
        default:  ;
      endcase
    end
  end

  spi_sticky_status #(
    .WIDTH (WIDTH)
  ) u_status (
    .FX2_CLK   (FX2_CLK),
    .FX2_RST_n (FX2_RST_n),
    .event_in  (event_in),
    .clr_mask  (clr_mask),
    .status    (status)
  );

  assign ctrl0    = ctrl_q[0];
  assign ctrl1    = ctrl_q[1];
  assign ctrl2    = ctrl_q[2];
  assign ctrl3    = ctrl_q[3];
  assign ctrl4    = ctrl_q[4];
  assign ctrl5    = ctrl_q[5];
  assign ctrl6    = ctrl_q[6];
  assign ctrl7    = ctrl_q[7];
  assign wr_pulse = wr_pulse_q;
  assign wr_count = wr_count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_ctrl_regfile.sv
// Directed bench for spi_ctrl_regfile: hand-computed expectations for writes,
// reads, W1C status, back-to-back strobes, bad addresses, wrap and reset.
module tb_spi_ctrl_regfile;

  logic       FX2_CLK;
  logic       FX2_RST_n;
  logic [7:0] event_in;
  logic [7:0] ctrl [8];
  logic [7:0] wr_pulse;
  logic [7:0] status;
  logic [7:0] wr_count;
  logic       err;

  logic [7:0] exp_ctrl [8];
  int         n_checks;
  int         n_errors;

  spi_ctrl_regfile_if #(.WIDTH(8)) bus ();

  spi_ctrl_regfile #(
    .WIDTH    (8),
    .CTRL_RST (8'h00)
  ) dut (
    .FX2_CLK   (FX2_CLK),
    .FX2_RST_n (FX2_RST_n),
    .bus       (bus),
    .event_in  (event_in),
    .ctrl0     (ctrl[0]),
    .ctrl1     (ctrl[1]),
    .ctrl2     (ctrl[2]),
    .ctrl3     (ctrl[3]),
    .ctrl4     (ctrl[4]),
    .ctrl5     (ctrl[5]),
    .ctrl6     (ctrl[6]),
    .ctrl7     (ctrl[7]),
    .wr_pulse  (wr_pulse),
    .status    (status),
    .wr_count  (wr_count),
    .err       (err)
  );

  initial FX2_CLK = 1'b0;
  always #5 FX2_CLK = ~FX2_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge FX2_CLK);
    #1;
  endtask

  task automatic strobe_on(input logic [6:0] a, input logic [7:0] d);
    bus.saddr   = a;
    bus.sdata   = d;
    bus.sstrobe = 1'b1;
  endtask

  // Returns just after the commit edge of a single transfer.
  task automatic write_xfer(input logic [6:0] a, input logic [7:0] d);
    strobe_on(a, d);
    tick();
    bus.sstrobe = 1'b0;
    tick();
  endtask

  task automatic check_all_ctrl(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_ctrl%0d", tag, i), 32'(ctrl[i]), 32'(exp_ctrl[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    FX2_RST_n   = 1'b0;
    event_in    = 8'h00;
    bus.saddr   = 7'h00;
    bus.sdata   = 8'h00;
    bus.sstrobe = 1'b0;
    for (int i = 0; i < 8; i++)
      exp_ctrl[i] = 8'h00;

    repeat (3) tick();
    FX2_RST_n = 1'b1;
    tick();

    check_all_ctrl("reset");
    check("reset_wr_pulse", 32'(wr_pulse), 32'h00);
    check("reset_status",   32'(status),   32'h00);
    check("reset_wr_count", 32'(wr_count), 32'h00);
    check("reset_err",      32'(err),      32'h0);

    // Single write to addr 3: nothing visible after capture, commit on next edge.
    strobe_on(7'h03, 8'hA5);
    tick();
    bus.sstrobe = 1'b0;
    check("wr3_pulse_not_early", 32'(wr_pulse), 32'h00);
    check("wr3_ctrl2_not_early", 32'(ctrl[2]),  32'h00);
    tick();
    exp_ctrl[2] = 8'hA5;
    check("wr3_pulse",    32'(wr_pulse), 32'h04);
    check("wr3_wr_count", 32'(wr_count), 32'h01);
    check_all_ctrl("wr3");
    tick();
    check("wr3_pulse_gone", 32'(wr_pulse), 32'h00);

    // Read transfer to addr 1 must not write ctrl0.
    write_xfer(7'h21, 8'hFF);
    check("rd_pulse",    32'(wr_pulse), 32'h00);
    check("rd_wr_count", 32'(wr_count), 32'h01);
    check("rd_err",      32'(err),      32'h0);
    check_all_ctrl("rd");

    // Sticky status: set by events, cleared by W1C writes to addr 9.
    event_in = 8'h81;
    tick();
    event_in = 8'h00;
    check("st_set", 32'(status), 32'h81);
    write_xfer(7'h09, 8'h01);
    check("st_clr", 32'(status), 32'h80);
    check("st_clr_wr_count", 32'(wr_count), 32'h02);
    check("st_clr_pulse", 32'(wr_pulse), 32'h00);
    strobe_on(7'h09, 8'h81);
    event_in = 8'h01;
    tick();
    bus.sstrobe = 1'b0;
    tick();
    event_in = 8'h00;
    check("st_set_wins", 32'(status), 32'h01);
    check("st_set_wins_wr_count", 32'(wr_count), 32'h03);
    tick();
    check("st_hold", 32'(status), 32'h01);

    // Back-to-back strobes to addr 1 and addr 8.
    strobe_on(7'h01, 8'h11);
    tick();
    strobe_on(7'h08, 8'h88);
    tick();
    bus.sstrobe = 1'b0;
    exp_ctrl[0] = 8'h11;
    check("b2b_pulse0", 32'(wr_pulse), 32'h01);
    check("b2b_ctrl0",  32'(ctrl[0]),  32'h11);
    tick();
    exp_ctrl[7] = 8'h88;
    check("b2b_pulse7", 32'(wr_pulse), 32'h80);
    check("b2b_wr_count", 32'(wr_count), 32'h05);
    check_all_ctrl("b2b");
    tick();
    check("b2b_pulse_gone", 32'(wr_pulse), 32'h00);

    // Unmapped addresses 0 and 31 raise the sticky error only.
    write_xfer(7'h00, 8'hEE);
    check("bad0_err",      32'(err),      32'h1);
    check("bad0_wr_count", 32'(wr_count), 32'h05);
    check("bad0_pulse",    32'(wr_pulse), 32'h00);
    write_xfer(7'h1F, 8'hEE);
    check("bad31_err",      32'(err),      32'h1);
    check("bad31_wr_count", 32'(wr_count), 32'h05);
    check_all_ctrl("bad");
    repeat (2) tick();
    check("bad_err_sticky", 32'(err), 32'h1);

    // Reset on the cycle after the strobe discards the captured write to addr 4.
    strobe_on(7'h04, 8'h5A);
    tick();
    bus.sstrobe = 1'b0;
    #2 FX2_RST_n = 1'b0;
    #5 FX2_RST_n = 1'b1;
    for (int i = 0; i < 8; i++)
      exp_ctrl[i] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rstmid_pulse_%0d", k), 32'(wr_pulse), 32'h00);
      check($sformatf("rstmid_ctrl3_%0d", k), 32'(ctrl[3]),  32'h00);
    end
    check("rstmid_wr_count", 32'(wr_count), 32'h00);
    check("rstmid_err",      32'(err),      32'h0);
    check("rstmid_status",   32'(status),   32'h00);
    check_all_ctrl("rstmid");

    // 257 consecutive writes to addr 1: counter wraps to 1.
    for (int i = 0; i < 257; i++) begin
      strobe_on(7'h01, 8'(i) ^ 8'h5A);
      tick();
      if (i == 255)
        check("wrap_count_255", 32'(wr_count), 32'hFF);
    end
    bus.sstrobe = 1'b0;
    tick();
    exp_ctrl[0] = 8'h5A;
    check("wrap_wr_count", 32'(wr_count), 32'h01);
    check("wrap_pulse",    32'(wr_pulse), 32'h01);
    check_all_ctrl("wrap");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
